// File: rtl/mem_wb_elastic_stage.sv
// rtl/mem_wb_elastic_stage.sv - MEM/WB two-entry elastic buffer with load extraction and writeback select
//
// Ports:
//   cpu_clk, cpu_rst_n             clock, asynchronous active-low reset
//   flush_i                        drop every buffered entry
//   in_valid_i / in_ready_o        MEM-side handshake
//   inst_i, reg_write_i, rd_i      instruction word, write enable, destination register
//   result_sel_i                   00/11 ALU, 01 load, 10 PC+4
//   alu_res_i, mem_rdata_i         ALU result / load address, raw aligned memory word
//   pc_plus_4_i, funct3_i          link value, load type
//   out_valid_o / out_ready_i      WB-side handshake
//   inst_o, reg_write_o, rd_o      head instruction, effective write enable, destination
//   wb_data_o, misaligned_o        final writeback value, head load misaligned
//   occupancy_o                    entries held (0..2)

module mem_wb_elastic_stage #(
    parameter int INST_WIDTH          = 32,
    parameter int INST_ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH          = 32,
    parameter int REGISTER_ADDR_WIDTH = 5
) (
    input  logic                           cpu_clk,
    input  logic                           cpu_rst_n,
    input  logic                           flush_i,
    input  logic                           in_valid_i,
    output logic                           in_ready_o,
    input  logic [INST_WIDTH-1:0]          inst_i,
    input  logic                           reg_write_i,
    input  logic [1:0]                     result_sel_i,
    input  logic [DATA_WIDTH-1:0]          alu_res_i,
    input  logic [DATA_WIDTH-1:0]          mem_rdata_i,
    input  logic [REGISTER_ADDR_WIDTH-1:0] rd_i,
    input  logic [INST_ADDR_WIDTH-1:0]     pc_plus_4_i,
    input  logic [2:0]                     funct3_i,
    output logic                           out_valid_o,
    input  logic                           out_ready_i,
    output logic [INST_WIDTH-1:0]          inst_o,
    output logic                           reg_write_o,
    output logic [REGISTER_ADDR_WIDTH-1:0] rd_o,
    output logic [DATA_WIDTH-1:0]          wb_data_o,
    output logic                           misaligned_o,
    output logic [1:0]                     occupancy_o
);

    localparam int OFFW = $clog2(DATA_WIDTH / 8);
    localparam bit IS64 = (DATA_WIDTH == 64);

    typedef struct packed {
        logic [INST_WIDTH-1:0]          inst;
        logic                           reg_write;
        logic [REGISTER_ADDR_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0]          wb_data;
        logic                           misaligned;
    } entry_t;

    entry_t h_q, s_q, new_e;
    logic   h_v, s_v;
    logic   accept, pop;

    // Load extraction: shift the addressed lane down to bit 0, then pick width.
    logic [OFFW-1:0]       off;
    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] ld_data;
    logic                  ld_mis;
    logic                  mis;

    assign off     = alu_res_i[OFFW-1:0];
    assign shifted = mem_rdata_i >> {off, 3'b000};

    always_comb begin
        ld_data = '0;
        ld_mis  = 1'b0;
        case (funct3_i)
            3'b000: ld_data = DATA_WIDTH'($signed(shifted[7:0]));
            3'b100: ld_data = DATA_WIDTH'(shifted[7:0]);
            3'b001: begin
                ld_data = DATA_WIDTH'($signed(shifted[15:0]));
                ld_mis  = off[0];
            end
            3'b101: begin
                ld_data = DATA_WIDTH'(shifted[15:0]);
                ld_mis  = off[0];
            end
            3'b010: begin
                ld_data = DATA_WIDTH'($signed(shifted[31:0]));
                ld_mis  = |off[1:0];
            end
            3'b110: begin
                if (IS64) begin
                    ld_data = DATA_WIDTH'(shifted[31:0]);
                    ld_mis  = |off[1:0];
                end
            end
            3'b011: begin
                // Doubleword: only offset 0 is legal, where shifted equals the raw word.
                if (IS64) begin
                    ld_data = shifted;
                    ld_mis  = |off;
                end
            end
            default: ;
        endcase
    end

    // Writeback selection happens at capture; a misaligned load is neutered here.
    always_comb begin
        mis           = (result_sel_i == 2'b01) && ld_mis;
        new_e.inst       = inst_i;
        new_e.rd         = rd_i;
        new_e.misaligned = mis;
        new_e.reg_write  = reg_write_i & ~mis;
        case (result_sel_i)
            2'b01:   new_e.wb_data = mis ? '0 : ld_data;
            2'b10:   new_e.wb_data = DATA_WIDTH'(pc_plus_4_i);
            default: new_e.wb_data = alu_res_i;
        endcase
    end

    // in_ready depends only on the skid register, never on out_ready_i.
    assign in_ready_o = ~s_v;
    assign accept     = in_valid_i & in_ready_o;
    assign pop        = h_v & out_ready_i;

    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            h_v <= 1'b0;
            s_v <= 1'b0;
            h_q <= '0;
            s_q <= '0;
        end else if (flush_i) begin
            h_v <= 1'b0;
            s_v <= 1'b0;
        end else if (pop && s_v) begin
            h_q <= s_q;
            s_v <= 1'b0;
        end else if (pop) begin
            if (accept) begin
                h_q <= new_e;
            end else begin
                h_v <= 1'b0;
            end
        end else if (accept) begin
            if (!h_v) begin
                h_q <= new_e;
                h_v <= 1'b1;
            end else begin
                s_q <= new_e;
                s_v <= 1'b1;
            end
        end
    end

    assign out_valid_o  = h_v;
    assign inst_o       = h_q.inst;
    assign rd_o         = h_q.rd;
    assign wb_data_o    = h_q.wb_data;
    assign misaligned_o = h_q.misaligned;
    assign reg_write_o  = h_v & h_q.reg_write & (|h_q.rd);
    assign occupancy_o  = {1'b0, h_v} + {1'b0, s_v};

endmodule

// File: tb/tb_mem_wb_elastic_stage.sv
// tb/tb_mem_wb_elastic_stage.sv - scoreboard bench for mem_wb_elastic_stage (32-bit and 64-bit builds)

module tb_mem_wb_elastic_stage;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst_n;
    always #5 cpu_clk = ~cpu_clk;

    // 32-bit build
    logic        flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] inst_in, alu_res, mem_rdata, pc_plus_4, inst_out, wb_data;
    logic        reg_write_in, reg_write_out, misaligned;
    logic [1:0]  result_sel, occupancy;
    logic [4:0]  rd_in, rd_out;
    logic [2:0]  funct3;

    mem_wb_elastic_stage dut (
        .cpu_clk(cpu_clk), .cpu_rst_n(cpu_rst_n), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .inst_i(inst_in),
        .reg_write_i(reg_write_in), .result_sel_i(result_sel), .alu_res_i(alu_res),
        .mem_rdata_i(mem_rdata), .rd_i(rd_in), .pc_plus_4_i(pc_plus_4), .funct3_i(funct3),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .inst_o(inst_out),
        .reg_write_o(reg_write_out), .rd_o(rd_out), .wb_data_o(wb_data),
        .misaligned_o(misaligned), .occupancy_o(occupancy)
    );

    // 64-bit build
    logic        d_in_valid, d_in_ready, d_out_valid, d_reg_write, d_mis;
    logic [63:0] d_alu, d_rdata, d_wb;
    logic [2:0]  d_funct3;
    logic [31:0] d_inst;
    logic [4:0]  d_rd;
    logic [1:0]  d_occ;

    mem_wb_elastic_stage #(.DATA_WIDTH(64)) dut64 (
        .cpu_clk(cpu_clk), .cpu_rst_n(cpu_rst_n), .flush_i(1'b0),
        .in_valid_i(d_in_valid), .in_ready_o(d_in_ready), .inst_i(32'h0000_0013),
        .reg_write_i(1'b1), .result_sel_i(2'b01), .alu_res_i(d_alu),
        .mem_rdata_i(d_rdata), .rd_i(5'd7), .pc_plus_4_i(32'h0), .funct3_i(d_funct3),
        .out_valid_o(d_out_valid), .out_ready_i(1'b1), .inst_o(d_inst),
        .reg_write_o(d_reg_write), .rd_o(d_rd), .wb_data_o(d_wb),
        .misaligned_o(d_mis), .occupancy_o(d_occ)
    );

    typedef struct {
        logic [31:0] inst;
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] wb;
        logic        mis;
    } exp_t;

    exp_t exp_q[$];
    exp_t pend;
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Present one instruction to the 32-bit DUT along with the values WB must see.
    task automatic drive(input logic [31:0] i, input logic rw, input logic [1:0] sel,
                         input logic [31:0] alu, input logic [31:0] md, input logic [4:0] rd,
                         input logic [31:0] pc, input logic [2:0] f3,
                         input logic [31:0] ewb, input logic erw, input logic emis);
        in_valid = 1'b1; inst_in = i; reg_write_in = rw; result_sel = sel;
        alu_res = alu; mem_rdata = md; rd_in = rd; pc_plus_4 = pc; funct3 = f3;
        pend.inst = i; pend.rw = erw; pend.rd = rd; pend.wb = ewb; pend.mis = emis;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    // Observe handshakes at the falling edge, then advance one clock.
    task automatic tick();
        exp_t e;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pop", 64'(inst_out), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("sb_inst", 64'(inst_out), 64'(e.inst));
                chk("sb_rd", 64'(rd_out), 64'(e.rd));
                chk("sb_wb_data", 64'(wb_data), 64'(e.wb));
                chk("sb_reg_write", 64'(reg_write_out), 64'(e.rw));
                chk("sb_misaligned", 64'(misaligned), 64'(e.mis));
            end
        end
        if (flush) exp_q.delete();
        else if (in_valid && in_ready) exp_q.push_back(pend);
        @(posedge cpu_clk);
        @(negedge cpu_clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cpu_rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
        in_valid = 1'b0; inst_in = '0; reg_write_in = 1'b0; result_sel = '0;
        alu_res = '0; mem_rdata = '0; rd_in = '0; pc_plus_4 = '0; funct3 = '0;
        d_in_valid = 1'b0; d_alu = '0; d_rdata = '0; d_funct3 = '0;
        pend = '{default: '0};
        repeat (2) @(negedge cpu_clk);

        // Reset state
        chk("rst_out_valid", 64'(out_valid), 0);
        chk("rst_in_ready", 64'(in_ready), 1);
        chk("rst_reg_write", 64'(reg_write_out), 0);
        chk("rst_rd", 64'(rd_out), 0);
        chk("rst_wb_data", 64'(wb_data), 0);
        chk("rst_inst", 64'(inst_out), 0);
        chk("rst_misaligned", 64'(misaligned), 0);
        chk("rst_occupancy", 64'(occupancy), 0);
        cpu_rst_n = 1'b1;
        @(negedge cpu_clk);

        // Streaming LW x5 then ADD x6 with WB always ready
        out_ready = 1'b1;
        drive(32'h0000_2283, 1, 2'b01, 32'h1000, 32'hDEAD_BEEF, 5, 0, 3'b010, 32'hDEAD_BEEF, 1, 0);
        tick();
        chk("stream_valid_1", 64'(out_valid), 1);
        chk("stream_occ_1", 64'(occupancy), 1);
        chk("stream_ready_1", 64'(in_ready), 1);
        chk("stream_rw_1", 64'(reg_write_out), 1);
        drive(32'h0070_0333, 1, 2'b00, 32'd7, 32'h0, 6, 0, 3'b000, 32'd7, 1, 0);
        tick();
        chk("stream_occ_2", 64'(occupancy), 1);
        chk("stream_ready_2", 64'(in_ready), 1);
        idle();
        tick();
        chk("stream_drained", 64'(out_valid), 0);

        // Load extraction on 0x80FF7F01, back to back
        drive(32'h1001, 1, 2'b01, 32'h2003, 32'h80FF_7F01, 10, 0, 3'b000, 32'hFFFF_FF80, 1, 0);
        tick();
        drive(32'h1002, 1, 2'b01, 32'h2001, 32'h80FF_7F01, 11, 0, 3'b100, 32'h0000_007F, 1, 0);
        tick();
        drive(32'h1003, 1, 2'b01, 32'h2002, 32'h80FF_7F01, 12, 0, 3'b001, 32'hFFFF_80FF, 1, 0);
        tick();
        drive(32'h1004, 1, 2'b01, 32'h2000, 32'h80FF_7F01, 13, 0, 3'b101, 32'h0000_7F01, 1, 0);
        tick();
        drive(32'h1005, 1, 2'b01, 32'h2001, 32'h80FF_7F01, 14, 0, 3'b001, 32'h0, 0, 1);
        tick();
        chk("lh_mis_flag", 64'(misaligned), 1);
        chk("lh_mis_rw", 64'(reg_write_out), 0);
        drive(32'h1006, 1, 2'b01, 32'h2002, 32'h80FF_7F01, 15, 0, 3'b010, 32'h0, 0, 1);
        tick();
        drive(32'h1007, 1, 2'b01, 32'h2000, 32'h80FF_7F01, 16, 0, 3'b011, 32'h0, 1, 0);
        tick();
        // Misalignment ignored for non-load result select
        drive(32'h1008, 1, 2'b00, 32'h2001, 32'h80FF_7F01, 17, 0, 3'b001, 32'h2001, 1, 0);
        tick();
        idle();
        tick();

        // Back-pressure: A, B accepted, C held, then drained in order
        out_ready = 1'b0;
        drive(32'hA, 1, 2'b00, 32'hAAAA, 0, 1, 0, 0, 32'hAAAA, 1, 0);
        tick();
        drive(32'hB, 1, 2'b00, 32'hBBBB, 0, 2, 0, 0, 32'hBBBB, 1, 0);
        tick();
        chk("bp_occ_full", 64'(occupancy), 2);
        chk("bp_in_ready", 64'(in_ready), 0);
        drive(32'hC, 1, 2'b00, 32'hCCCC, 0, 3, 0, 0, 32'hCCCC, 1, 0);
        tick();
        tick();
        chk("bp_occ_hold", 64'(occupancy), 2);
        chk("bp_head_A", 64'(inst_out), 64'hA);
        out_ready = 1'b1;
        tick();
        chk("bp_ready_after_pop", 64'(in_ready), 1);
        tick();
        idle();
        tick();
        tick();
        chk("bp_empty", 64'(out_valid), 0);
        chk("bp_queue_empty", 64'(exp_q.size()), 0);

        // Flush at occupancy 2 with a same-cycle input
        out_ready = 1'b0;
        drive(32'hD1, 1, 2'b00, 1, 0, 4, 0, 0, 1, 1, 0);
        tick();
        drive(32'hD2, 1, 2'b00, 2, 0, 4, 0, 0, 2, 1, 0);
        tick();
        chk("fl_occ_before", 64'(occupancy), 2);
        drive(32'hD3, 1, 2'b00, 3, 0, 4, 0, 0, 3, 1, 0);
        flush = 1'b1;
        in_valid = 1'b1;
        // Skid full, so force the drop path through an empty-skid flush as well.
        tick();
        flush = 1'b0;
        idle();
        chk("fl_valid", 64'(out_valid), 0);
        chk("fl_occ", 64'(occupancy), 0);
        chk("fl_ready", 64'(in_ready), 1);
        drive(32'hD4, 1, 2'b00, 4, 0, 4, 0, 0, 4, 1, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        idle();
        chk("fl_drop_new", 64'(out_valid), 0);
        out_ready = 1'b1;
        tick();

        // JAL link value, rd=x1 then rd=x0
        drive(32'h0040_00EF, 1, 2'b10, 32'h5555, 0, 1, 32'h104, 0, 32'h104, 1, 0);
        tick();
        chk("jal_rw", 64'(reg_write_out), 1);
        drive(32'h0040_006F, 1, 2'b10, 32'h5555, 0, 0, 32'h104, 0, 32'h104, 0, 0);
        tick();
        chk("jal_x0_rw", 64'(reg_write_out), 0);
        chk("jal_x0_wb", 64'(wb_data), 64'h104);
        idle();
        tick();

        // 64-bit build loads
        d_in_valid = 1'b1; d_funct3 = 3'b010; d_alu = 64'h2000; d_rdata = 64'h0000_0000_8000_0000;
        @(negedge cpu_clk);
        chk("d64_lw", d_wb, 64'hFFFF_FFFF_8000_0000);
        chk("d64_lw_rw", 64'(d_reg_write), 1);
        d_funct3 = 3'b110;
        @(negedge cpu_clk);
        chk("d64_lwu", d_wb, 64'h0000_0000_8000_0000);
        d_funct3 = 3'b010; d_alu = 64'h2004; d_rdata = 64'h8000_0000_0000_0000;
        @(negedge cpu_clk);
        chk("d64_lw_off4", d_wb, 64'hFFFF_FFFF_8000_0000);
        d_funct3 = 3'b011; d_alu = 64'h2000; d_rdata = 64'h1122_3344_5566_7788;
        @(negedge cpu_clk);
        chk("d64_ld", d_wb, 64'h1122_3344_5566_7788);
        d_alu = 64'h2004;
        @(negedge cpu_clk);
        chk("d64_ld_mis", 64'(d_mis), 1);
        chk("d64_ld_mis_wb", d_wb, 0);
        d_funct3 = 3'b111;
        @(negedge cpu_clk);
        chk("d64_illegal", d_wb, 0);

        // Mid-stream asynchronous reset with both entries full
        out_ready = 1'b0;
        drive(32'hE1, 1, 2'b00, 9, 0, 9, 0, 0, 9, 1, 0);
        tick();
        drive(32'hE2, 1, 2'b00, 10, 0, 10, 0, 0, 10, 1, 0);
        tick();
        idle();
        #2 cpu_rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(out_valid), 0);
        chk("arst_occ", 64'(occupancy), 0);
        chk("arst_ready", 64'(in_ready), 1);
        chk("arst_wb", 64'(wb_data), 0);
        chk("arst_inst", 64'(inst_out), 0);
        chk("arst_rd", 64'(rd_out), 0);
        chk("arst_d64_valid", 64'(d_out_valid), 0);
        chk("arst_d64_wb", d_wb, 0);
        exp_q.delete();
        @(negedge cpu_clk);
        cpu_rst_n = 1'b1;
        d_in_valid = 1'b0;
        @(negedge cpu_clk);
        chk("post_rst_valid", 64'(out_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_wb_elastic_stage.md
Name: mem_wb_elastic_stage

Overview:
- Next-generation MEM/WB boundary for the five-stage core. Replaces the plain always-load register with a 2-entry elastic buffer using valid/ready handshakes.
- Performs load-data extraction (byte/half/word select with sign or zero extension) and writeback-source selection at capture time. WB sees only registered, final writeback data.
- Supports flush and downstream back-pressure, so a future multi-cycle WB or register-file port arbiter can stall MEM without losing instructions.

Parameters:
- INST_WIDTH, 32, instruction word width carried for debug/trace
- INST_ADDR_WIDTH, 32, PC width
- DATA_WIDTH, 32, datapath width; legal values 32 or 64
- REGISTER_ADDR_WIDTH, 5, register index width

Ports:
- cpu_clk  in  1  clock
- cpu_rst_n  in  1  asynchronous active-low reset
- flush_i  in  1  drop all buffered entries
- in_valid_i  in  1  MEM presents an instruction
- in_ready_o  out  1  stage can accept this cycle
- inst_i  in  INST_WIDTH  instruction word
- reg_write_i  in  1  instruction writes rd
- result_sel_i  in  2  00 ALU, 01 load, 10 PC+4, 11 ALU
- alu_res_i  in  DATA_WIDTH  ALU result / load address
- mem_rdata_i  in  DATA_WIDTH  raw aligned memory word
- rd_i  in  REGISTER_ADDR_WIDTH  destination register
- pc_plus_4_i  in  INST_ADDR_WIDTH  link value
- funct3_i  in  3  load type
- out_valid_o  out  1  head entry valid
- out_ready_i  in  1  WB consumes head this cycle
- inst_o  out  INST_WIDTH  head instruction
- reg_write_o  out  1  effective write enable
- rd_o  out  REGISTER_ADDR_WIDTH  head destination
- wb_data_o  out  DATA_WIDTH  final writeback value
- misaligned_o  out  1  head load was misaligned
- occupancy_o  out  2  entries held (0..2)

Behaviour:
- Storage: head entry H (drives outputs) and skid entry S. Each has a valid bit and fields {inst, reg_write, rd, wb_data, misaligned}.
- Reset (async assert, sync deassert to the clock edge): H.v=S.v=0, all stored fields 0. Outputs: out_valid_o=0, in_ready_o=1, reg_write_o=0, rd_o=0, wb_data_o=0, inst_o=0, misaligned_o=0, occupancy_o=0.
- in_ready_o = !S.v, driven from a register with no combinational path from out_ready_i. out_valid_o = H.v.
- Transfers: accept = in_valid_i & in_ready_o; pop = H.v & out_ready_i.
- Next-state, priority top-down:
  - flush_i: H.v, S.v <= 0; the same-cycle accept is discarded.
  - pop & S.v: H <= S, S.v <= 0 (no accept is possible, because in_ready_o=0).
  - pop & !S.v: H <= new if accept, else H.v <= 0.
  - !pop & accept: H <= new if !H.v, else S <= new.
  - Otherwise hold.
- Latency: 1 cycle from accept to out_valid_o when empty. Throughput: 1/cycle with out_ready_i held high.
- occupancy_o = H.v + S.v. It is never 2 with H.v=0.
- Load extraction:
  - Offset = alu_res_i[log2(DATA_WIDTH/8)-1:0].
  - funct3 000 LB, 100 LBU: byte at offset.
  - 001 LH, 101 LHU: half at offset; misaligned if offset[0]=1.
  - 010 LW: word at offset; misaligned if offset[1:0]!=0. Sign-extend from bit 31 when DATA_WIDTH=64.
  - 110 LWU (64 only): zero-extend.
  - 011 LD (64 only): misaligned if offset!=0.
  - Unsigned variants zero-extend; others sign-extend to DATA_WIDTH.
  - Illegal funct3 for the width: data = 0, misaligned = 0.
- Misalignment only matters when result_sel_i=01. If set, stored wb_data = 0 and the stored reg_write is forced to 0.
- wb_data by result_sel_i: 00/11 alu_res_i, 01 extracted load, 10 pc_plus_4_i zero-extended or truncated to DATA_WIDTH.
- reg_write_o = H.v & H.reg_write & (H.rd != 0). It is never asserted when out_valid_o=0.
- Output fields of an invalid H hold their last values. Only reg_write_o is gated.
- Reset asserted mid-transfer clears both entries immediately. No partial entry survives.

Test Plan:
- Stream: LW x5 with alu_res=0x1000 and mem_rdata=0xDEADBEEF, then ADD x6 with alu_res=7, out_ready_i=1 -> outputs appear 1 cycle after each accept: {x5, 0xDEADBEEF, reg_write=1}, then {x6, 7}. occupancy_o stays 1 and in_ready_o stays 1.
- Load extraction on mem_rdata=0x80FF7F01: LB offset 3 -> 0xFFFFFF80; LBU offset 1 -> 0x0000007F; LH offset 2 -> 0xFFFF80FF; LHU offset 0 -> 0x00007F01; LH offset 1 -> misaligned_o=1, wb_data_o=0, reg_write_o=0.
- Back-pressure: hold out_ready_i=0 and send 3 back-to-back instructions -> first two accepted, occupancy_o=2, in_ready_o=0 on the next cycle, third held by MEM. Release out_ready_i -> drained in order A, B, C with no loss and no duplication.
- Flush with occupancy 2 and in_valid_i=1 in the same cycle -> next cycle out_valid_o=0, occupancy_o=0, in_ready_o=1, new instruction not captured.
- JAL with result_sel=10, pc_plus_4=0x00000104, rd=x1 -> wb_data_o=0x104. Same instruction with rd=x0 -> reg_write_o=0.
- DATA_WIDTH=64 build: LW with mem_rdata=0x00000000_80000000 -> 0xFFFFFFFF_80000000; LWU -> 0x00000000_80000000. Mid-stream async reset pulse -> all outputs 0 immediately and in_ready_o=1.
